// File: rtl/ksa16_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor (diff = a + ~b + 1) with
// valid/ready flow control and borrow/overflow/zero flags.
module ksa16_sub_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned L1     = LEVELS / 2;

    logic v0, v1, v2;
    logic adv0, adv1, adv2;

    logic [WIDTH-1:0] s0_g, s0_p;
    logic             s0_am, s0_bm;
    logic [WIDTH-1:0] s1_g, s1_p, s1_x;
    logic             s1_am, s1_bm;

    logic [WIDTH-1:0] g0_c, p0_c;
    logic [WIDTH-1:0] g1_c, p1_c;
    logic [WIDTH-1:0] g2_c, p2_c;
    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;

    // Backpressure ripples from the output stage toward the input.
    assign adv2      = ~v2 | out_ready;
    assign adv1      = ~v1 | adv2;
    assign adv0      = ~v0 | adv1;
    assign in_ready  = adv0;
    assign out_valid = v2;

    // Generate/propagate for a + ~b, with the +1 carry-in folded into bit 0.
    always_comb begin
        g0_c    = a & ~b;
        p0_c    = a ^ ~b;
        g0_c[0] = g0_c[0] | p0_c[0];
    end

    // Lower prefix levels; walking i downward keeps level-l operands unmodified.
    always_comb begin
        g1_c = s0_g;
        p1_c = s0_p;
        for (int l = 0; l < int'(L1); l++) begin
            for (int i = int'(WIDTH) - 1; i >= (1 << l); i--) begin
                g1_c[i] = g1_c[i] | (p1_c[i] & g1_c[i - (1 << l)]);
                p1_c[i] = p1_c[i] & p1_c[i - (1 << l)];
            end
        end
    end

    // Upper prefix levels, sum and flags.
    always_comb begin
        g2_c = s1_g;
        p2_c = s1_p;
        for (int l = int'(L1); l < int'(LEVELS); l++) begin
            for (int i = int'(WIDTH) - 1; i >= (1 << l); i--) begin
                g2_c[i] = g2_c[i] | (p2_c[i] & g2_c[i - (1 << l)]);
                p2_c[i] = p2_c[i] & p2_c[i - (1 << l)];
            end
        end
        diff_c = s1_x ^ {g2_c[WIDTH-2:0], 1'b1};
        ovf_c  = (s1_am != s1_bm) && (diff_c[WIDTH-1] != s1_am);
    end

    // Data registers load only with a valid op so bubbles never carry X forward.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            v0     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            s0_g   <= '0;
            s0_p   <= '0;
            s0_am  <= 1'b0;
            s0_bm  <= 1'b0;
            s1_g   <= '0;
            s1_p   <= '0;
            s1_x   <= '0;
            s1_am  <= 1'b0;
            s1_bm  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (adv0) begin
                v0 <= in_valid;
                if (in_valid) begin
                    s0_g  <= g0_c;
                    s0_p  <= p0_c;
                    s0_am <= a[WIDTH-1];
                    s0_bm <= b[WIDTH-1];
                end
            end
            if (adv1) begin
                v1 <= v0;
                if (v0) begin
                    s1_g  <= g1_c;
                    s1_p  <= p1_c;
                    s1_x  <= s0_p;
                    s1_am <= s0_am;
                    s1_bm <= s0_bm;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    diff   <= diff_c;
                    borrow <= ~g2_c[WIDTH-1];
                    ovf    <= ovf_c;
                    zero   <= (diff_c == '0);
                end
            end
        end
    end

endmodule
